// File: rtl/fc1_wstream_fifo.sv
// fc1_wstream_fifo: show-ahead FIFO buffering FC1 weight groups for the FC engine.
// Head group is presented combinationally; count is held in its own register.
module fc1_wstream_fifo #(
    parameter int NUM_PE = 4,
    parameter int DEPTH  = 16,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [NUM_PE*8-1:0]   wr_data,
    output logic                  wr_ready,
    input  logic                  rd_next,
    output logic signed [7:0]     w_stream [NUM_PE],
    output logic                  w_valid,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [15:0]           consumed
);
    localparam int AW = $clog2(DEPTH);

    logic [NUM_PE*8-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wp;
    logic [AW-1:0]       r_rp;
    logic [CW-1:0]       r_count;
    logic                r_ovf;
    logic                r_udf;
    logic [15:0]         r_consumed;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [NUM_PE*8-1:0] w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_push  = wr_en & (~w_full | rd_next) & ~clear;
    assign w_pop   = rd_next & ~w_empty & ~clear;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_consumed <= '0;
        end else if (clear) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_consumed <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp       <= r_rp + 1'b1;
                r_consumed <= r_consumed + 16'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (wr_en && w_full && !rd_next) begin
                r_ovf <= 1'b1;
            end
            if (rd_next && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign w_head = r_mem[r_rp];

    always_comb begin
        for (int p = 0; p < NUM_PE; p++) begin
            w_stream[p] = w_empty ? 8'sd0 : w_head[8*p +: 8];
        end
    end

    assign w_valid   = ~w_empty;
    assign wr_ready  = ~w_full;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_ovf;
    assign underflow = r_udf;
    assign consumed  = r_consumed;

endmodule

// File: tb/tb_fc1_wstream_fifo.sv
// tb_fc1_wstream_fifo: queue scoreboard plus vector table for fc1_wstream_fifo.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_fc1_wstream_fifo;
    logic              clk;
    logic              rst_ni;
    logic              clear;
    logic              wr_en;
    logic [31:0]       wr_data;
    logic              wr_ready;
    logic              rd_next;
    logic signed [7:0] w_stream [4];
    logic              w_valid;
    logic [4:0]        count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;
    logic [15:0]       consumed;

    fc1_wstream_fifo #(.NUM_PE(4), .DEPTH(16)) dut (
        .clk(clk), .rst_ni(rst_ni), .clear(clear),
        .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_next(rd_next), .w_stream(w_stream), .w_valid(w_valid),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow), .consumed(consumed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q_model [$];
    bit          m_ovf;
    bit          m_udf;
    logic [15:0] m_cons;
    int          m_pushes;
    int          m_pops;

    typedef struct {
        bit          wr;
        bit          rd;
        bit          clr;
        logic [31:0] d;
        int          e_cnt;
        bit          e_val;
        logic [31:0] e_head;
        bit          e_udf;
        int          e_cons;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [31:0] ws_packed();
        return {w_stream[3], w_stream[2], w_stream[1], w_stream[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q_model.size();
        chk({tag, ".count"}, 32'(count), 32'(sz));
        chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        chk({tag, ".full"}, 32'(full), 32'(sz == 16));
        chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(sz != 16));
        chk({tag, ".w_valid"}, 32'(w_valid), 32'(sz != 0));
        chk({tag, ".head"}, ws_packed(), (sz == 0) ? 32'h0 : q_model[0]);
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
        chk({tag, ".consumed"}, 32'(consumed), 32'(m_cons));
    endtask

    // Drive one cycle, advance the reference queue, then check after the edge
    task automatic cyc(input bit wr, input bit rd, input bit clr,
                       input logic [31:0] d, input string tag);
        bit m_full;
        bit m_empty;
        logic [31:0] popped;
        wr_en   = wr;
        rd_next = rd;
        clear   = clr;
        wr_data = d;
        m_full  = (q_model.size() == 16);
        m_empty = (q_model.size() == 0);
        if (clr) begin
            q_model.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_cons = 16'd0;
        end else begin
            if (wr && m_full && !rd) m_ovf = 1'b1;
            if (rd && m_empty) m_udf = 1'b1;
            if (rd && !m_empty) begin
                popped = q_model.pop_front();
                chk({tag, ".pop_data"}, ws_packed(), popped);
                m_cons = m_cons + 16'd1;
                m_pops++;
            end
            if (wr && (!m_full || rd)) begin
                q_model.push_back(d);
                m_pushes++;
            end
        end
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_next = 1'b0;
        clear   = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rst_ni  = 1'b0;
        clear   = 1'b0;
        wr_en   = 1'b0;
        rd_next = 1'b0;
        wr_data = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_cons  = 16'd0;

        tbl[0] = '{wr:0, rd:0, clr:1, d:32'h0,        e_cnt:0, e_val:0, e_head:32'h0,        e_udf:0, e_cons:0};
        tbl[1] = '{wr:0, rd:1, clr:0, d:32'h0,        e_cnt:0, e_val:0, e_head:32'h0,        e_udf:1, e_cons:0};
        tbl[2] = '{wr:1, rd:1, clr:0, d:32'h80807F7F, e_cnt:1, e_val:1, e_head:32'h80807F7F, e_udf:1, e_cons:0};
        tbl[3] = '{wr:1, rd:0, clr:0, d:32'h11223344, e_cnt:2, e_val:1, e_head:32'h80807F7F, e_udf:1, e_cons:0};
        tbl[4] = '{wr:0, rd:1, clr:0, d:32'h0,        e_cnt:1, e_val:1, e_head:32'h11223344, e_udf:1, e_cons:1};

        repeat (3) @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_idle");

        for (int k = 0; k < 16; k++)
            cyc(1, 0, 0, 32'h04030201 + k * 32'h04040404, "fill");
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.count", 32'(count), 32'd16);
        chk("fill.wr_ready", 32'(wr_ready), 32'd0);
        for (int p = 0; p < 4; p++)
            chk("fill.lane", 32'(w_stream[p]), 32'(p + 1));

        for (int k = 0; k < 16; k++)
            cyc(0, 1, 0, 32'h0, "drain");
        chk("drain.empty", 32'(empty), 32'd1);
        chk("drain.consumed", 32'(consumed), 32'd16);

        for (int k = 0; k < 16; k++)
            cyc(1, 0, 0, 32'h10203040 + 32'(k), "refill");
        cyc(1, 0, 0, 32'hFFFFFFFF, "ovf");
        chk("ovf.flag", 32'(overflow), 32'd1);
        chk("ovf.count", 32'(count), 32'd16);
        chk("ovf.head", ws_packed(), 32'h10203040);
        cyc(1, 1, 0, 32'hFFFFFFFF, "full_bypass");
        chk("full_bypass.count", 32'(count), 32'd16);
        for (int k = 0; k < 15; k++)
            cyc(0, 1, 0, 32'h0, "drain2");
        for (int p = 0; p < 4; p++)
            chk("tail.lane_neg1", 32'(w_stream[p]), 32'hFFFFFFFF);
        cyc(0, 1, 0, 32'h0, "drain2_last");
        chk("drain2.empty", 32'(empty), 32'd1);

        foreach (tbl[i]) begin
            cyc(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].d, "vec");
            chk("vec.count", 32'(count), 32'(tbl[i].e_cnt));
            chk("vec.valid", 32'(w_valid), 32'(tbl[i].e_val));
            chk("vec.head", ws_packed(), tbl[i].e_head);
            chk("vec.udf", 32'(underflow), 32'(tbl[i].e_udf));
            chk("vec.cons", 32'(consumed), 32'(tbl[i].e_cons));
        end

        cyc(0, 0, 1, 32'h0, "clr0");
        cyc(1, 1, 0, 32'h80807F7F, "empty_bypass");
        chk("eb.lane0", 32'(w_stream[0]), 32'd127);
        chk("eb.lane1", 32'(w_stream[1]), 32'd127);
        chk("eb.lane2", 32'(w_stream[2]), 32'hFFFFFF80);
        chk("eb.lane3", 32'(w_stream[3]), 32'hFFFFFF80);

        m_pushes = 0;
        m_pops   = 0;
        for (int i = 0; i < 600; i++) begin
            if (i >= 40 && m_pushes >= 34 && m_pops >= 34) break;
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, 0,
                $urandom, "wrap");
        end
        chk("wrap.pushes_ge32", 32'(m_pushes >= 32), 32'd1);
        chk("wrap.pops_ge32", 32'(m_pops >= 32), 32'd1);

        cyc(0, 0, 1, 32'h0, "clr1");
        for (int k = 0; k < 5; k++)
            cyc(1, 0, 0, 32'hA0A0A0A0 + 32'(k), "pre_clr");
        cyc(1, 0, 1, 32'hDEADBEEF, "clr_wr");
        chk("clr_wr.count", 32'(count), 32'd0);
        cyc(1, 0, 0, 32'h01020304, "post_clr");
        chk("post_clr.head", ws_packed(), 32'h01020304);

        for (int k = 0; k < 2; k++)
            cyc(1, 0, 0, 32'h55667788 + 32'(k), "pre_rst");
        chk("pre_rst.count", 32'(count), 32'd3);
        #3;
        rst_ni = 1'b0;
        q_model.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_cons = 16'd0;
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        check_all("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fc1_wstream_fifo.md
# fc1_wstream_fifo

Show-ahead FIFO that buffers FC1 weight groups written by the host and presents them, one group per step, to the FC engine's weight-stream input. Each host word carries one signed 8-bit weight per PE lane. Each consume pulse from the FC engine (its "next group" request) pops the head group. The block decouples host write bursts from engine consumption and exposes occupancy and sticky error flags for host readback.

## Interface
Parameters:
- NUM_PE, 4, number of PE lanes (signed int8 weights per group)
- DEPTH, 16, groups of storage; power of two, ≥2
- CW, $clog2(DEPTH)+1, width of count

Ports:
- clk  in  1  system clock, rising edge
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- clear  in  1  synchronous flush pulse
- wr_en  in  1  host write strobe, one group per cycle
- wr_data  in  NUM_PE*8  lane p = wr_data[8p+7:8p]
- wr_ready  out  1  = ~full
- rd_next  in  1  consume pulse from FC engine; pops head group
- w_stream  out  NUM_PE x 8 signed  head group lanes; all zero when empty
- w_valid  out  1  head group present (= ~empty)
- count  out  CW  groups stored, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: write dropped
- underflow  out  1  sticky: rd_next while empty
- consumed  out  16  groups popped since reset/clear, wraps at 65535→0

## Operation
- Storage: DEPTH × NUM_PE × 8 array, write pointer wp and read pointer rp, each log2(DEPTH) bits, wrapping modulo DEPTH. count is held in a register, not derived from the pointers.
- Push condition: wr_en & (~full | rd_next).
  - On push, store wr_data at wp and increment wp.
  - Full with simultaneous rd_next: the write is accepted and count is unchanged.
- Pop condition: rd_next & ~empty. On pop, increment rp and consumed.
- Write dropped: wr_en & full & ~rd_next. Storage, wp and count are unchanged; overflow is set.
- rd_next & empty sets underflow, and nothing pops. If wr_en is asserted in the same cycle, the write is still accepted and count becomes 1.
- count next value: +1 on push only, −1 on pop only, unchanged on both or neither.
- w_stream is read combinationally from storage at rp, masked to zero when empty. Lane order is preserved with no sign change; lane p of w_stream comes from wr_data[8p+7:8p].
- clear is a synchronous flush.
  - Zeroes wp, rp, count, consumed, overflow and underflow.
  - Overrides any wr_en/rd_next in the same cycle; that write is discarded and no flag is set.
  - Storage contents need not be cleared.
- Sticky flags clear only on reset or clear.

## Timing
- Reset (rst_ni low, asynchronous assert, released on a clock edge):
  - Outputs: w_valid=0, w_stream all 0, count=0, empty=1, full=0, wr_ready=1, overflow=0, underflow=0, consumed=0.
  - Pointers are 0.
- Reset mid-operation discards all buffered groups immediately, without waiting for a clock edge.
- Write latency: a group written at edge N into an empty FIFO is on w_stream with w_valid=1 immediately after edge N. There is no extra read cycle.
- Pop latency: rd_next at edge N advances to the next group immediately after N. If that was the last group, w_valid=0 and w_stream=0 after N.
- One push and one pop maximum per cycle. Sustained simultaneous wr_en/rd_next at any occupancy 1..DEPTH holds count steady.
- rd_next is a single-cycle pulse. A multi-cycle assertion pops once per cycle.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble. Data order is preserved across the wrap.
- All status outputs are registers or functions of registers only; there is no combinational path from inputs to outputs.

## Test plan
- Reset/idle: hold rst_ni=0 for 3 cycles, then release.
  - Required: count=0, empty=1, wr_ready=1, w_valid=0, w_stream={0,0,0,0}, flags=0.
- Fill/drain order:
  - Write 16 groups with wr_data=32'h04030201 + k*32'h04040404 (k=0..15). Required: full=1, count=16, wr_ready=0; head lanes are {1,2,3,4} (lane0..3).
  - Then pulse rd_next 16 times. Required: each group appears in order; after the last pop, empty=1 and consumed=16.
- Overflow and full bypass:
  - At full, wr_en alone with 32'hFFFFFFFF. Required: overflow=1, count stays 16, head unchanged.
  - Then wr_en+rd_next together. Required: count stays 16, the new group lands at the tail, and it reads out last as {−1,−1,−1,−1}.
- Underflow and empty bypass:
  - rd_next on empty. Required: underflow=1, consumed=0.
  - Then wr_en+rd_next in the same cycle with 32'h80807F7F. Required: count=1, w_stream={127,127,−128,−128}, w_valid=1.
- Wrap stress: 40 cycles of random wr_en/rd_next.
  - Required: a scoreboard shows no loss or reordering; count matches the model every cycle; pointers wrap at least twice.
- clear and async reset mid-burst:
  - Assert clear together with wr_en at count=5. Required: count=0, flags=0, consumed=0, and the write is discarded.
  - Drop rst_ni between clock edges at count=3. Required: outputs reach their reset values immediately, before the next edge.
